io_bus_bridge: RTL and testbench

IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

---
 rtl/io_bus_bridge_pkg.sv | 22 ++
 rtl/io_bus_bridge_timeout.sv | 41 ++++
 rtl/io_bus_bridge.sv | 167 ++++++++++++++++
 tb/tb_io_bus_bridge.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_bridge_pkg.sv
// Shared types for the core-to-pin-bus bridge: transaction kinds and bridge FSM states.
package io_bus_bridge_pkg;

    typedef enum logic [1:0] {
        KIND_PC     = 2'd0,
        KIND_MAR    = 2'd1,
        KIND_MDR_WR = 2'd2,
        KIND_MDR_RD = 2'd3
    } bus_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_t;

    function automatic logic is_mdr(input bus_kind_t kind);
        return (kind == KIND_MDR_WR) || (kind == KIND_MDR_RD);
    endfunction

endpackage

// File: rtl/io_bus_bridge_timeout.sv
// Handshake watchdog: counts consecutive stalled cycles while run is high.
module io_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry fires on the TIMEOUT-th stalled cycle; a progress beat that cycle cancels it.
    assign expired = run && !clear && (cnt_q == LIM);

    // Next count: restart on progress or outside a handshake phase, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q != LIM) begin
            cnt_d = cnt_q + CW'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_bus_bridge.sv
// Serialises core words onto a narrow pin bus (LSB beat first) and reassembles read replies.
module io_bus_bridge
    import io_bus_bridge_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int PIN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  bus_kind_t         req_kind,
    input  logic [WORD_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              err,
    input  logic              err_clr,
    input  logic [PIN_W-1:0]  pin_in,
    output logic [PIN_W-1:0]  pin_out,
    input  logic              ard_receive_ready,
    input  logic              ard_data_ready,
    output logic              pin_valid,
    output logic              pin_ack,
    output logic              bus_pc,
    output logic              bus_mar,
    output logic              bus_mdr
);

    localparam int BEATS = WORD_W / PIN_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [WORD_W-1:0] LANE_MASK = WORD_W'({PIN_W{1'b1}});
    localparam logic [BW-1:0]     LAST      = BW'(BEATS - 1);

    bridge_state_t     state_q, state_d;
    bus_kind_t         kind_q, kind_d;
    logic [WORD_W-1:0] word_q, word_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              rsp_valid_q, rsp_valid_d, err_q, err_d;

    logic              tx_fire, rx_fire, last_beat, to_run, to_clear, to_expired, active;
    int                lane_sh;
    logic [PIN_W-1:0]  tx_beat;
    logic [WORD_W-1:0] rx_merge;

    assign tx_fire   = (state_q == ST_SEND) && ard_receive_ready;
    assign rx_fire   = (state_q == ST_RECV) && ard_data_ready;
    assign last_beat = (beat_q == LAST);
    assign active    = (state_q == ST_SEND) || (state_q == ST_RECV);
    assign to_run    = active;
    assign to_clear  = tx_fire || rx_fire;
    assign lane_sh   = PIN_W * int'(beat_q);
    assign tx_beat   = PIN_W'(word_q >> lane_sh);
    assign rx_merge  = (rx_q & ~(LANE_MASK << lane_sh)) | (WORD_W'(pin_in) << lane_sh);

    io_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (to_clear),
        .run     (to_run),
        .expired (to_expired)
    );

    // Next-state and datapath updates for the bridge FSM.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        word_d      = word_q;
        rx_d        = rx_q;
        beat_d      = beat_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        err_d       = err_clr ? 1'b0 : err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    kind_d  = req_kind;
                    // A read still clocks out BEATS command beats, all zero.
                    word_d  = (req_kind == KIND_MDR_RD) ? {WORD_W{1'b0}} : req_data;
                    rx_d    = {WORD_W{1'b0}};
                    beat_d  = {BW{1'b0}};
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (to_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (tx_fire) begin
                    if (last_beat) begin
                        beat_d  = {BW{1'b0}};
                        state_d = (kind_q == KIND_MDR_RD) ? ST_RECV : ST_DONE;
                    end else begin
                        beat_d  = beat_q + BW'(1'b1);
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_RECV: begin
                if (to_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (rx_fire) begin
                    rx_d = rx_merge;
                    if (last_beat) begin
                        beat_d      = {BW{1'b0}};
                        rsp_data_d  = rx_merge;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        beat_d  = beat_q + BW'(1'b1);
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_PC;
            word_q      <= {WORD_W{1'b0}};
            rx_q        <= {WORD_W{1'b0}};
            beat_q      <= {BW{1'b0}};
            rsp_data_q  <= {WORD_W{1'b0}};
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            word_q      <= word_d;
            rx_q        <= rx_d;
            beat_q      <= beat_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign pin_valid = (state_q == ST_SEND);
    assign pin_out   = pin_valid ? tx_beat : {PIN_W{1'b0}};
    assign pin_ack   = rx_fire;
    assign bus_pc    = active && (kind_q == KIND_PC);
    assign bus_mar   = active && (kind_q == KIND_MAR);
    assign bus_mdr   = active && is_mdr(kind_q);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Randomised and directed checks of io_bus_bridge against a transaction-level reference model.
module tb_io_bus_bridge;
    import io_bus_bridge_pkg::*;

    localparam int W = 16, P = 8, B = W / P, TMO = 255;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1, req_valid = 1'b0, err_clr = 1'b0;
    logic ard_receive_ready = 1'b0, ard_data_ready = 1'b0;
    bus_kind_t req_kind = KIND_PC;
    logic [W-1:0] req_data = '0;
    logic [P-1:0] pin_in = '0;
    logic req_ready, rsp_valid, err, pin_valid, pin_ack, bus_pc, bus_mar, bus_mdr;
    logic [W-1:0] rsp_data;
    logic [P-1:0] pin_out;

    io_bus_bridge #(.WORD_W(W), .PIN_W(P), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .err(err), .err_clr(err_clr), .pin_in(pin_in), .pin_out(pin_out),
        .ard_receive_ready(ard_receive_ready), .ard_data_ready(ard_data_ready),
        .pin_valid(pin_valid), .pin_ack(pin_ack), .bus_pc(bus_pc), .bus_mar(bus_mar), .bus_mdr(bus_mdr));

    // 24-bit build: three beats per word.
    logic r2_valid = 1'b0, ard2_rr = 1'b0, ard2_dr = 1'b0;
    bus_kind_t r2_kind = KIND_PC;
    logic [23:0] r2_data = '0, rsp2_d;
    logic [7:0] p2_in = '0, p2_out;
    logic rr2, rsp2_v, err2, pv2, pa2, pc2, mar2, mdr2;

    io_bus_bridge #(.WORD_W(24), .PIN_W(8), .TIMEOUT(TMO)) dut24 (
        .clock(clock), .reset(reset), .req_valid(r2_valid), .req_ready(rr2),
        .req_kind(r2_kind), .req_data(r2_data), .rsp_valid(rsp2_v), .rsp_data(rsp2_d),
        .err(err2), .err_clr(1'b0), .pin_in(p2_in), .pin_out(p2_out),
        .ard_receive_ready(ard2_rr), .ard_data_ready(ard2_dr),
        .pin_valid(pv2), .pin_ack(pa2), .bus_pc(pc2), .bus_mar(mar2), .bus_mdr(mdr2));

    int n_chk = 0, n_fail = 0;
    bit chk_on = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: pending outbound beats, pending inbound beats, stall count.
    logic [P-1:0] m_tx[$];
    int m_rx_left = 0, m_rx_idx = 0, m_stall = 0;
    logic [W-1:0] m_rx_acc = '0, m_rsp_word = '0;
    bit m_read = 1'b0, m_done = 1'b0, m_pulse = 1'b0, m_err = 1'b0;
    bus_kind_t m_kind = KIND_PC;

    task automatic model_step();
        bit prog, nerr;
        if (reset) begin
            m_tx.delete();
            m_rx_left = 0; m_done = 1'b0; m_pulse = 1'b0; m_err = 1'b0;
            m_rsp_word = '0; m_stall = 0; m_kind = KIND_PC;
        end else begin
            nerr = m_err && !err_clr;
            m_pulse = 1'b0;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_tx.size() > 0 || m_rx_left > 0) begin
                prog = (m_tx.size() > 0) ? ard_receive_ready : ard_data_ready;
                if (prog) begin
                    m_stall = 0;
                    if (m_tx.size() > 0) begin
                        void'(m_tx.pop_front());
                        if (m_tx.size() == 0) begin
                            if (m_read) begin
                                m_rx_left = B; m_rx_idx = 0; m_rx_acc = '0;
                            end else begin
                                m_done = 1'b1;
                            end
                        end
                    end else begin
                        m_rx_acc = m_rx_acc | (W'(pin_in) << (P * m_rx_idx));
                        m_rx_idx++;
                        m_rx_left--;
                        if (m_rx_left == 0) begin
                            m_rsp_word = m_rx_acc; m_pulse = 1'b1; m_done = 1'b1;
                        end
                    end
                end else begin
                    m_stall++;
                    if (m_stall >= TMO) begin
                        m_tx.delete(); m_rx_left = 0; m_stall = 0; nerr = 1'b1;
                    end
                end
            end else if (req_valid) begin
                m_kind = req_kind;
                m_read = (req_kind == KIND_MDR_RD);
                m_stall = 0;
                for (int k = 0; k < B; k++)
                    m_tx.push_back(m_read ? 8'h00 : P'(req_data >> (P * k)));
            end
            m_err = nerr;
        end
    endtask

    // Every cycle: compare DUT outputs with the model, then advance the model.
    always @(negedge clock) begin : compare
        bit busy;
        if (chk_on) begin
            busy = (m_tx.size() > 0) || (m_rx_left > 0);
            check("req_ready", req_ready, !busy && !m_done && !reset);
            check("pin_valid", pin_valid, m_tx.size() > 0);
            check("pin_out", pin_out, (m_tx.size() > 0) ? m_tx[0] : 8'h00);
            check("pin_ack", pin_ack, (m_tx.size() == 0) && (m_rx_left > 0) && ard_data_ready);
            check("bus_pc", bus_pc, busy && m_kind == KIND_PC);
            check("bus_mar", bus_mar, busy && m_kind == KIND_MAR);
            check("bus_mdr", bus_mdr, busy && (m_kind == KIND_MDR_WR || m_kind == KIND_MDR_RD));
            check("rsp_valid", rsp_valid, m_pulse);
            check("rsp_data", rsp_data, m_rsp_word);
            check("err", err, m_err);
        end
        model_step();
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cyc();
        chk_on = 1'b1;
        cyc();
        @(negedge clock);
        check("rst_ready", req_ready, 1'b0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_pin_out", pin_out, 8'h00);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", req_ready, 1'b1);

        // MAR write, LSB beat first.
        cyc();
        ard_receive_ready = 1'b1;
        req_valid = 1'b1; req_kind = KIND_MAR; req_data = 16'hA55A;
        cyc();
        req_valid = 1'b0;
        @(negedge clock);
        check("mar_beat0", pin_out, 8'h5A);
        check("mar_tag0", bus_mar, 1'b1);
        cyc();
        @(negedge clock);
        check("mar_beat1", pin_out, 8'hA5);
        check("mar_tag1", bus_mar, 1'b1);
        cyc();
        @(negedge clock);
        check("mar_done_tag", bus_mar, 1'b0);
        check("mar_done_ready", req_ready, 1'b0);
        cyc();
        @(negedge clock);
        check("mar_idle_ready", req_ready, 1'b1);

        // Read: two zero command beats, then two reply beats.
        req_valid = 1'b1; req_kind = KIND_MDR_RD; req_data = 16'hFFFF;
        cyc();
        req_valid = 1'b0;
        @(negedge clock);
        check("rd_cmd_beat", pin_out, 8'h00);
        check("rd_tag", bus_mdr, 1'b1);
        cyc();
        cyc();
        ard_data_ready = 1'b1; pin_in = 8'h34;
        @(negedge clock);
        check("rd_ack", pin_ack, 1'b1);
        cyc();
        pin_in = 8'h12;
        cyc();
        ard_data_ready = 1'b0;
        @(negedge clock);
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_data", rsp_data, 16'h1234);
        cyc();
        @(negedge clock);
        check("rd_rsp_pulse_end", rsp_valid, 1'b0);
        check("rd_rsp_hold", rsp_data, 16'h1234);

        // PC write stalled three cycles on beat 0.
        ard_receive_ready = 1'b0;
        req_valid = 1'b1; req_kind = KIND_PC; req_data = 16'hA55A;
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_hold", pin_out, 8'h5A);
            cyc();
        end
        ard_receive_ready = 1'b1;
        @(negedge clock);
        check("stall_release", pin_out, 8'h5A);
        cyc();
        @(negedge clock);
        check("stall_beat1", pin_out, 8'hA5);
        cyc();
        cyc();

        // Timeout after 255 stalled cycles, then clear.
        ard_receive_ready = 1'b0;
        req_valid = 1'b1; req_kind = KIND_MAR; req_data = 16'h0F0F;
        cyc();
        req_valid = 1'b0;
        repeat (254) cyc();
        @(negedge clock);
        check("tmo_not_yet", err, 1'b0);
        check("tmo_still_send", pin_valid, 1'b1);
        cyc();
        @(negedge clock);
        check("tmo_err", err, 1'b1);
        check("tmo_idle", req_ready, 1'b1);
        check("tmo_no_rsp", rsp_valid, 1'b0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        @(negedge clock);
        check("err_cleared", err, 1'b0);

        // Clear held through a second timeout: set wins.
        err_clr = 1'b1;
        req_valid = 1'b1; req_kind = KIND_PC;
        cyc();
        req_valid = 1'b0;
        repeat (255) cyc();
        err_clr = 1'b0;
        @(negedge clock);
        check("tmo_set_wins", err, 1'b1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;

        // Reset in the middle of a read.
        ard_receive_ready = 1'b1;
        req_valid = 1'b1; req_kind = KIND_MDR_RD;
        cyc();
        req_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        @(negedge clock);
        check("mid_rst_ready", req_ready, 1'b0);
        check("mid_rst_pin_valid", pin_valid, 1'b0);
        check("mid_rst_tag", bus_mdr, 1'b0);
        check("mid_rst_rsp_data", rsp_data, 16'h0000);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_release", req_ready, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset = ($urandom_range(399, 0) == 0);
            req_valid = $urandom_range(1, 0);
            req_kind = bus_kind_t'($urandom_range(3, 0));
            req_data = W'($urandom);
            ard_receive_ready = ($urandom_range(3, 0) != 0);
            ard_data_ready = ($urandom_range(3, 0) != 0);
            pin_in = P'($urandom);
            err_clr = ($urandom_range(15, 0) == 0);
        end
        cyc();
        reset = 1'b0; req_valid = 1'b0; err_clr = 1'b0;
        repeat (12) cyc();

        // 24-bit build: three beats each way.
        ard2_rr = 1'b1;
        r2_valid = 1'b1; r2_kind = KIND_MAR; r2_data = 24'hC3B2A1;
        cyc();
        r2_valid = 1'b0;
        @(negedge clock);
        check("w24_beat0", p2_out, 8'hA1);
        check("w24_tag", mar2, 1'b1);
        cyc();
        @(negedge clock);
        check("w24_beat1", p2_out, 8'hB2);
        cyc();
        @(negedge clock);
        check("w24_beat2", p2_out, 8'hC3);
        cyc();
        @(negedge clock);
        check("w24_done", pv2, 1'b0);
        cyc();
        r2_valid = 1'b1; r2_kind = KIND_MDR_RD;
        cyc();
        r2_valid = 1'b0;
        repeat (3) cyc();
        ard2_dr = 1'b1; p2_in = 8'h11;
        @(negedge clock);
        check("w24_ack", pa2, 1'b1);
        cyc();
        p2_in = 8'h22;
        cyc();
        p2_in = 8'h33;
        cyc();
        ard2_dr = 1'b0;
        @(negedge clock);
        check("w24_rsp_valid", rsp2_v, 1'b1);
        check("w24_rsp_data", rsp2_d, 24'h332211);
        check("w24_rsp_tag", mdr2, 1'b0);
        cyc();
        @(negedge clock);
        check("w24_pulse_end", rsp2_v, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
